// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed 7-segment driver for an NDIG-digit BCD result.
// A LOAD strobe captures digits and decimal points into a pending buffer.
// The buffer is committed only at a scan-frame boundary, so a frame never
// shows a mix of old and new data. Leading-zero blanking is optional and
// follows BLANK_LZ live. SEG/AN are registered and lag the scan index by
// one clock.

module bcd_seg_scan #(
  parameter int NDIG       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                LOAD,
  input  logic [4*NDIG-1:0]   DIGIT_IN,
  input  logic [NDIG-1:0]     DP_IN,
  input  logic                BLANK_LZ,
  output logic                PENDING,
  output logic [7:0]          SEG,
  output logic [NDIG-1:0]     AN
);

  localparam int              PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int              IW       = $clog2(NDIG);
  localparam logic [PW-1:0]   PRE_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]   IDX_MAX  = IW'(NDIG - 1);
  localparam logic [7:0]      SEG_OFF  = {8{ACTIVE_LOW}};
  localparam logic [NDIG-1:0] AN_OFF   = {NDIG{ACTIVE_LOW}};

  logic [PW-1:0]     prescaler_q, prescaler_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic [NDIG-1:0]   dp_disp_q, dp_disp_d;
  logic [NDIG-1:0]   dp_pend_q, dp_pend_d;
  logic              pending_q, pending_d;
  logic [7:0]        seg_q, seg_d;
  logic [NDIG-1:0]   an_q, an_d;

  logic              tick;
  logic              frame_end;
  logic [3:0]        cur_digit;
  logic              run_zero;
  logic [NDIG-1:0]   lz_mask;
  logic              blank;
  logic [7:0]        seg_raw;
  logic [NDIG-1:0]   an_raw;

  // Segment pattern (active-high, no dp) for one BCD value; 10-15 show a dash.
  function automatic logic [7:0] decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h40;
    endcase
    return s;
  endfunction

  // Slot prescaler and scan index; the frame ends when the index wraps.
  always_comb begin
    tick        = (prescaler_q == PRE_MAX);
    frame_end   = tick && (idx_q == IDX_MAX);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Capture on LOAD and commit at a frame boundary; a LOAD on the boundary edge
  // keeps its new data pending while the old buffer is committed.
  always_comb begin
    disp_d    = disp_q;
    dp_disp_d = dp_disp_q;
    pend_d    = pend_q;
    dp_pend_d = dp_pend_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      disp_d    = pend_q;
      dp_disp_d = dp_pend_q;
      pending_d = 1'b0;
    end
    if (LOAD) begin
      pend_d    = DIGIT_IN;
      dp_pend_d = DP_IN;
      pending_d = 1'b1;
    end
  end

  // Leading-zero mask: a digit above digit 0 is blankable when it and all more
  // significant digits are zero.
  always_comb begin
    run_zero = 1'b1;
    lz_mask  = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      run_zero   = run_zero && (disp_q[4*k +: 4] == 4'd0);
      lz_mask[k] = run_zero && (k != 0);
    end
  end

  // Drive pattern for the current slot, polarity applied at the end.
  always_comb begin
    cur_digit      = disp_q[{idx_q, 2'b00} +: 4];
    blank          = BLANK_LZ && lz_mask[idx_q];
    seg_raw        = decode(cur_digit);
    seg_raw[7]     = dp_disp_q[idx_q];
    an_raw         = '0;
    an_raw[idx_q]  = 1'b1;
    if (blank) begin
      seg_raw = '0;
      an_raw  = '0;
    end
    seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = ACTIVE_LOW ? ~an_raw : an_raw;
  end

  // State and output registers; reset drops pending data and blanks the display.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      dp_disp_q   <= '0;
      dp_pend_q   <= '0;
      pending_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      prescaler_q <= prescaler_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      dp_disp_q   <= dp_disp_d;
      dp_pend_q   <= dp_pend_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign PENDING = pending_q;
  assign SEG     = seg_q;
  assign AN      = an_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: scoreboard bench for bcd_seg_scan with NDIG=4,
// SCAN_DIV=4, ACTIVE_LOW=1. Each stimulus step queues the AN/SEG/PENDING
// values expected after its clock edge. A monitor on the falling edge pops
// each entry and compares it against the DUT.

module tb_bcd_seg_scan;

  logic        CLK;
  logic        nRST;
  logic        LOAD;
  logic [15:0] DIGIT_IN;
  logic [3:0]  DP_IN;
  logic        BLANK_LZ;
  logic        PENDING;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       pend;
    string      tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;

  logic [15:0] ld_mask;
  logic [15:0] ld_din [16];
  logic [3:0]  ld_dp  [16];

  bcd_seg_scan #(
    .NDIG       (4),
    .SCAN_DIV   (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .LOAD     (LOAD),
    .DIGIT_IN (DIGIT_IN),
    .DP_IN    (DP_IN),
    .BLANK_LZ (BLANK_LZ),
    .PENDING  (PENDING),
    .SEG      (SEG),
    .AN       (AN)
  );

  // 10-unit clock period
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Compare the live DUT outputs against one expected triple
  task automatic checkOutput(input string tag, input logic [3:0] exp_an,
                             input logic [7:0] exp_seg, input logic exp_pend);
    checks++;
    if (AN !== exp_an || SEG !== exp_seg || PENDING !== exp_pend) begin
      errors++;
      $display("[TB] FAIL %s: got AN=%b SEG=%h PENDING=%b, expected AN=%b SEG=%h PENDING=%b",
               tag, AN, SEG, PENDING, exp_an, exp_seg, exp_pend);
    end
  endtask

  // Monitor: one queued expectation is due at each falling edge
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, e.an, e.seg, e.pend);
    end
  end

  // Drive one cycle of inputs and queue the response due after that edge
  task automatic applyStimulus(input logic ld, input logic [15:0] din, input logic [3:0] dp,
                               input logic blk, input logic [3:0] ea, input logic [7:0] es,
                               input logic ep, input string tag);
    LOAD     = ld;
    DIGIT_IN = din;
    DP_IN    = dp;
    BLANK_LZ = blk;
    @(posedge CLK);
    sb.push_back('{an: ea, seg: es, pend: ep, tag: tag});
    #2;
  endtask

  // Schedule a LOAD at a given step of the next frame
  task automatic setLoad(input int step, input logic [15:0] din, input logic [3:0] dp);
    ld_mask[step] = 1'b1;
    ld_din[step]  = din;
    ld_dp[step]   = dp;
  endtask

  // One frame of 4 slots x 4 clocks; segs/ans packed slot3..slot0, pmask bit per step
  task automatic runFrame(input logic [31:0] segs, input logic [15:0] ans, input logic blk,
                          input logic [15:0] pmask, input int nsteps, input string name);
    for (int s = 0; s < nsteps; s++) begin
      int slot;
      slot = s / 4;
      applyStimulus(ld_mask[s], ld_din[s], ld_dp[s], blk, ans[4*slot +: 4],
                    segs[8*slot +: 8], pmask[s], $sformatf("%s step%0d", name, s));
    end
    ld_mask = '0;
  endtask

  initial begin
    ld_mask  = '0;
    for (int i = 0; i < 16; i++) begin
      ld_din[i] = '0;
      ld_dp[i]  = '0;
    end
    LOAD     = 1'b0;
    DIGIT_IN = '0;
    DP_IN    = '0;
    BLANK_LZ = 1'b0;
    nRST     = 1'b1;
    #1 nRST  = 1'b0;
    #1;
    checkOutput("reset state", 4'hF, 8'hFF, 1'b0);
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b1;

    // Idle after reset: every slot shows 0
    runFrame(32'hC0C0C0C0, 16'h7BDE, 1'b0, 16'h0000, 16, "idle");

    // Mid-frame load of 1234 with dp on digit 2
    setLoad(5, 16'h1234, 4'b0100);
    runFrame(32'hC0C0C0C0, 16'h7BDE, 1'b0, 16'h7FE0, 16, "load1234");

    // 1234 on display; queue 0070 for the blanking check
    setLoad(2, 16'h0070, 4'b0000);
    runFrame(32'hF924B099, 16'h7BDE, 1'b0, 16'h7FFC, 16, "show1234");

    // 0070 with leading-zero blanking; queue 0000 at the first step
    setLoad(0, 16'h0000, 4'b0000);
    runFrame(32'hFFFFF8C0, 16'hFFDE, 1'b1, 16'h7FFF, 16, "blank0070");

    // 0000 blanked down to digit 0; three loads, the last on the boundary edge
    setLoad(3, 16'h1111, 4'b0000);
    setLoad(9, 16'h2222, 4'b1000);
    setLoad(15, 16'h3333, 4'b0000);
    runFrame(32'hFFFFFFC0, 16'hFFFE, 1'b1, 16'hFFF8, 16, "blank0000");

    // 2222 committed, 3333 still pending until this frame ends
    runFrame(32'h24A4A4A4, 16'h7BDE, 1'b0, 16'h7FFF, 16, "show2222");

    // 3333 on display; queue 00AF
    setLoad(7, 16'h00AF, 4'b0000);
    runFrame(32'hB0B0B0B0, 16'h7BDE, 1'b0, 16'h7F80, 16, "show3333");

    // 00AF shows dashes in slots 0 and 1; stop mid-slot with 9876 pending
    setLoad(4, 16'h9876, 4'b1111);
    runFrame(32'hC0C0BFBF, 16'h7BDE, 1'b0, 16'h03F0, 10, "show00AF");

    // Asynchronous reset mid-slot with data pending
    @(negedge CLK);
    #1 nRST = 1'b0;
    #1;
    checkOutput("async reset", 4'hF, 8'hFF, 1'b0);
    LOAD = 1'b0;
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b1;

    // After release the pending 9876 is gone; queue 9865 to cover more digits
    setLoad(1, 16'h9865, 4'b0010);
    runFrame(32'hC0C0C0C0, 16'h7BDE, 1'b0, 16'h7FFE, 16, "postreset");

    runFrame(32'h90800292, 16'h7BDE, 1'b0, 16'h0000, 16, "show9865");

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
